// File: rtl/risk_job_scheduler.sv
// Round-robin job sequencer in front of the shared Mu/Sigma/S risk datapath.
// Accepts one job at a time, issues NSTEPS back-to-back step requests and
// returns the sum of the NSTEPS datapath results with the requester ID.
module risk_job_scheduler #(
  parameter int unsigned W      = 18,
  parameter int unsigned NSTEPS = 256
) (
  input  logic                          CLK,
  input  logic                          iRstN,
  input  logic [1:0]                    iReqValid,
  output logic [1:0]                    oReqReady,
  input  logic [2*W-1:0]                iMuBus,
  input  logic [2*W-1:0]                iSigmaBus,
  input  logic [2*W-1:0]                iSBus,
  output logic [W-1:0]                  oMu,
  output logic [W-1:0]                  oSigma,
  output logic [W-1:0]                  oS,
  output logic                          oDpStart,
  output logic [$clog2(NSTEPS)-1:0]     oStep,
  input  logic                          iDpValid,
  input  logic [W-1:0]                  iDpResult,
  output logic                          oRspValid,
  input  logic                          iRspReady,
  output logic                          oRspId,
  output logic [W+$clog2(NSTEPS)-1:0]   oRspSum,
  output logic                          oBusy,
  output logic                          oErr
);

  localparam int unsigned STW = $clog2(NSTEPS);
  localparam int unsigned SW  = W + STW;
  localparam int unsigned CW  = STW + 1;

  localparam logic [STW-1:0] LAST_STEP = STW'(NSTEPS - 1);
  localparam logic [CW-1:0]  LAST_RCV  = CW'(NSTEPS - 1);
  localparam logic [CW-1:0]  FULL_RCV  = CW'(NSTEPS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t         state_q, state_d;
  logic           rr_q;
  logic           grant;
  logic           accept;
  logic           take;
  logic           err_set;
  logic [1:0]     ready;
  logic [STW-1:0] step_q;
  logic [CW-1:0]  rcv_q;
  logic [SW-1:0]  acc_q;
  logic [W-1:0]   mu_q, sigma_q, s_q;
  logic           id_q;
  logic           dp_start_q, rsp_valid_q, busy_q, err_q;

  // Next-state, arbitration and accumulate/error qualifiers.
  always_comb begin
    state_d = state_q;
    ready   = 2'b00;
    grant   = rr_q;
    accept  = 1'b0;
    take    = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        grant   = iReqValid[rr_q] ? rr_q : ~rr_q;
        err_set = iDpValid;
        if (iReqValid[grant] && iRstN) begin
          ready   = grant ? 2'b10 : 2'b01;
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        take    = iDpValid && (rcv_q != FULL_RCV);
        err_set = iDpValid && !take;
        if (step_q == LAST_STEP) begin
          state_d = (take && rcv_q == LAST_RCV) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        take    = iDpValid && (rcv_q != FULL_RCV);
        err_set = iDpValid && !take;
        if (take && rcv_q == LAST_RCV) begin
          state_d = DONE;
        end
      end
      DONE: begin
        err_set = iDpValid;
        if (iRspReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with status outputs registered from the next state.
  always_ff @(posedge CLK or negedge iRstN) begin
    if (!iRstN) begin
      state_q     <= IDLE;
      dp_start_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dp_start_q  <= (state_d == ISSUE);
      rsp_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Latch the winning job's parameters and ID; advance the rr pointer.
  always_ff @(posedge CLK or negedge iRstN) begin
    if (!iRstN) begin
      mu_q    <= '0;
      sigma_q <= '0;
      s_q     <= '0;
      id_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else if (accept) begin
      mu_q    <= iMuBus[grant*W +: W];
      sigma_q <= iSigmaBus[grant*W +: W];
      s_q     <= iSBus[grant*W +: W];
      id_q    <= grant;
      rr_q    <= ~grant;
    end
  end

  // Step issue counter, result counter and accumulator.
  always_ff @(posedge CLK or negedge iRstN) begin
    if (!iRstN) begin
      step_q <= '0;
      rcv_q  <= '0;
      acc_q  <= '0;
    end else if (accept) begin
      step_q <= '0;
      rcv_q  <= '0;
      acc_q  <= '0;
    end else begin
      if (state_q == ISSUE) begin
        step_q <= step_q + STW'(1);
      end
      if (take) begin
        rcv_q <= rcv_q + CW'(1);
        acc_q <= acc_q + SW'(iDpResult);
      end
    end
  end

  // Sticky flag for results that do not belong to an active job.
  always_ff @(posedge CLK or negedge iRstN) begin
    if (!iRstN) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign oReqReady = ready;
  assign oMu       = mu_q;
  assign oSigma    = sigma_q;
  assign oS        = s_q;
  assign oDpStart  = dp_start_q;
  assign oStep     = step_q;
  assign oRspValid = rsp_valid_q;
  assign oRspId    = id_q;
  assign oRspSum   = acc_q;
  assign oBusy     = busy_q;
  assign oErr      = err_q;

endmodule
